// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    // All-zero word is sll $0,$0,0: decodes as a harmless nop.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load/bubble.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        stall_i,
    input  logic        load_i,
    input  logic [31:0] instr_i,
    input  logic [31:0] pcplus4_i,
    output logic [31:0] instr_o,
    output logic [31:0] pcplus4_o,
    output logic        valid_o
);

    logic [31:0] instr_q, instr_d;
    logic [31:0] pcplus4_q, pcplus4_d;
    logic        valid_q, valid_d;

    always_comb begin
        instr_d   = instr_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            if (load_i) begin
                instr_d   = instr_i;
                pcplus4_d = pcplus4_i;
                valid_d   = 1'b1;
            end else begin
                // Bubble: pcplus4 is left as-is since nothing consumes it while invalid.
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q   <= NOP_INSTR;
            pcplus4_q <= 32'h0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_o   = instr_q;
    assign pcplus4_o = pcplus4_q;
    assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ready handshake, redirect and stall absorption.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr_d,
    output logic [31:0] pcplus4_d,
    output logic        valid_d,
    output logic [5:0]  op_d
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  skid_q, skid_d;
    logic [31:0]  redir_pc_q, redir_pc_d;

    logic         ld;
    logic [31:0]  ld_instr;
    logic [31:0]  ld_pc4;
    logic [31:0]  pc_plus4;
    logic [31:0]  redirect_tgt;

    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = word_align(redirect_pc);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        redir_pc_d = redir_pc_q;
        imem_req   = 1'b0;
        ld         = 1'b0;
        ld_instr   = imem_rdata;
        ld_pc4     = pc_plus4;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    if (redirect_valid) begin
                        pc_d = redirect_tgt;
                    end else if (!stall_i) begin
                        ld   = 1'b1;
                        pc_d = pc_plus4;
                    end else begin
                        // Word arrived during a stall: park it and stop requesting.
                        skid_d  = imem_rdata;
                        pc_d    = pc_plus4;
                        state_d = HOLD;
                    end
                end else if (redirect_valid) begin
                    redir_pc_d = redirect_tgt;
                    state_d    = DRAIN;
                end
            end

            DRAIN: begin
                // The outstanding request must complete at its original address.
                imem_req = 1'b1;
                if (redirect_valid) begin
                    redir_pc_d = redirect_tgt;
                end
                if (imem_ready) begin
                    pc_d    = redirect_valid ? redirect_tgt : redir_pc_q;
                    state_d = FETCH;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    skid_d  = NOP_INSTR;
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    // pc_q already advanced past the parked word, so it is that word's PC+4.
                    ld       = 1'b1;
                    ld_instr = skid_q;
                    ld_pc4   = pc_q;
                    state_d  = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            skid_q     <= NOP_INSTR;
            redir_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            skid_q     <= skid_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign imem_addr = pc_q;

    if_id_reg u_if_id (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .flush_i   (flush_i),
        .stall_i   (stall_i),
        .load_i    (ld),
        .instr_i   (ld_instr),
        .pcplus4_i (ld_pc4),
        .instr_o   (instr_d),
        .pcplus4_o (pcplus4_d),
        .valid_o   (valid_d)
    );

    assign op_d = instr_d[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboarded bench for fetch_stage: directed handshake, stall, flush, redirect and wrap cases.
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] instr_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;
    logic [5:0]  op_d;
    logic        mem_hold = 1'b0;

    logic        rst1_n = 1'b0;
    logic        req1;
    logic [31:0] addr1;
    logic        ready1;
    logic [31:0] rdata1;
    logic [31:0] instr1;
    logic [31:0] pc41;
    logic        valid1;
    logic [5:0]  op1;

    int checks = 0;
    int failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic stall_seen = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2] ^ 6'h23, 10'h2A5, a[15:0]};
    endfunction

    assign imem_ready = imem_req & ~mem_hold;
    assign imem_rdata = mem_word(imem_addr);
    assign ready1     = req1;
    assign rdata1     = mem_word(addr1);

    fetch_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .stall_i        (stall_i),
        .flush_i        (flush_i),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_d        (instr_d),
        .pcplus4_d      (pcplus4_d),
        .valid_d        (valid_d),
        .op_d           (op_d)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .reset_n        (rst1_n),
        .imem_req       (req1),
        .imem_addr      (addr1),
        .imem_ready     (ready1),
        .imem_rdata     (rdata1),
        .stall_i        (1'b0),
        .flush_i        (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_d        (instr1),
        .pcplus4_d      (pc41),
        .valid_d        (valid1),
        .op_d           (op1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push0(input logic [31:0] a, input logic [31:0] pc4);
        exp_t e;
        e.instr = mem_word(a);
        e.pc4   = pc4;
        q0.push_back(e);
    endtask

    task automatic push1(input logic [31:0] a, input logic [31:0] pc4);
        exp_t e;
        e.instr = mem_word(a);
        e.pc4   = pc4;
        q1.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic rst_main();
        @(negedge clk);
        #1;
        chk("sb0_drained", 32'(q0.size()), 32'd0);
        reset_n        = 1'b0;
        mem_hold       = 1'b0;
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_valid", {31'h0, valid_d}, 32'h0);
        chk("rst_instr", instr_d, 32'h0);
        chk("rst_pc4", pcplus4_d, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    always @(posedge clk) stall_seen <= stall_i;

    // A valid word visible after an unstalled edge is a fresh IF/ID load.
    always @(negedge clk) begin
        if (valid_d && !stall_seen) begin
            if (q0.size() == 0) begin
                chk("sb0_unexpected", instr_d, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q0.pop_front();
                chk("sb0_instr", instr_d, e.instr);
                chk("sb0_pc4", pcplus4_d, e.pc4);
                chk("sb0_op", {26'h0, op_d}, {26'h0, e.instr[31:26]});
            end
        end
    end

    always @(negedge clk) begin
        if (valid1) begin
            if (q1.size() == 0) begin
                chk("sb1_unexpected", instr1, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("sb1_instr", instr1, e.instr);
                chk("sb1_pc4", pc41, e.pc4);
                chk("sb1_op", {26'h0, op1}, {26'h0, e.instr[31:26]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Zero-wait stream, then two wait states at address 8.
        rst_main();
        push0(32'h0, 32'h4);
        push0(32'h4, 32'h8);
        push0(32'h8, 32'hC);
        cyc();
        chk("A_addr0", imem_addr, 32'h0);
        chk("A_req", {31'h0, imem_req}, 32'h1);
        chk("A_no_valid_e1", {31'h0, valid_d}, 32'h0);
        cyc();
        chk("A_addr4", imem_addr, 32'h4);
        chk("A_valid_e2", {31'h0, valid_d}, 32'h1);
        cyc();
        chk("B_addr8_a", imem_addr, 32'h8);
        mem_hold = 1'b1;
        cyc();
        chk("B_addr8_b", imem_addr, 32'h8);
        chk("B_bubble1", {31'h0, valid_d}, 32'h0);
        cyc();
        chk("B_addr8_c", imem_addr, 32'h8);
        chk("B_bubble2", {31'h0, valid_d}, 32'h0);
        mem_hold = 1'b0;
        cyc();
        chk("B_addr12", imem_addr, 32'hC);
        mem_hold = 1'b1;

        // Stall while the word for address 4 returns.
        rst_main();
        push0(32'h0, 32'h4);
        push0(32'h4, 32'h8);
        push0(32'h8, 32'hC);
        cyc();
        cyc();
        chk("C_addr4", imem_addr, 32'h4);
        stall_i = 1'b1;
        cyc();
        chk("C_hold_req1", {31'h0, imem_req}, 32'h0);
        chk("C_held_instr", instr_d, mem_word(32'h0));
        cyc();
        chk("C_hold_req2", {31'h0, imem_req}, 32'h0);
        cyc();
        chk("C_hold_req3", {31'h0, imem_req}, 32'h0);
        stall_i = 1'b0;
        cyc();
        chk("C_resume_req", {31'h0, imem_req}, 32'h1);
        chk("C_resume_addr", imem_addr, 32'h8);
        cyc();
        mem_hold = 1'b1;

        // Flush with stall, then redirect out of HOLD (unaligned target).
        rst_main();
        push0(32'h0, 32'h4);
        push0(32'h40, 32'h44);
        cyc();
        cyc();
        stall_i = 1'b1;
        flush_i = 1'b1;
        cyc();
        chk("D_flush_valid", {31'h0, valid_d}, 32'h0);
        chk("D_flush_instr", instr_d, 32'h0);
        chk("D_hold_req", {31'h0, imem_req}, 32'h0);
        stall_i        = 1'b0;
        flush_i        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        cyc();
        redirect_valid = 1'b0;
        chk("D_redir_addr", imem_addr, 32'h40);
        chk("D_redir_req", {31'h0, imem_req}, 32'h1);
        cyc();
        mem_hold = 1'b1;

        // Redirect while the request for address 12 is waiting.
        rst_main();
        push0(32'h0, 32'h4);
        push0(32'h4, 32'h8);
        push0(32'h8, 32'hC);
        push0(32'h40, 32'h44);
        cyc();
        cyc();
        cyc();
        cyc();
        chk("E_addr12", imem_addr, 32'hC);
        mem_hold       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        cyc();
        redirect_valid = 1'b0;
        chk("E_drain_addr1", imem_addr, 32'hC);
        chk("E_drain_req", {31'h0, imem_req}, 32'h1);
        cyc();
        chk("E_drain_addr2", imem_addr, 32'hC);
        mem_hold = 1'b0;
        cyc();
        chk("E_new_addr", imem_addr, 32'h40);
        chk("E_drained_valid", {31'h0, valid_d}, 32'h0);
        cyc();
        mem_hold = 1'b1;

        // Asynchronous reset in the middle of DRAIN.
        rst_main();
        push0(32'h0, 32'h4);
        cyc();
        cyc();
        mem_hold       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        cyc();
        redirect_valid = 1'b0;
        chk("F_drain_addr", imem_addr, 32'h4);
        chk("F_drain_req", {31'h0, imem_req}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("F_async_req", {31'h0, imem_req}, 32'h0);
        chk("F_async_valid", {31'h0, valid_d}, 32'h0);
        chk("F_async_instr", instr_d, 32'h0);
        chk("F_async_pc4", pcplus4_d, 32'h0);
        chk("F_async_addr", imem_addr, 32'h0);
        rst_main();
        mem_hold = 1'b1;

        // Second instance: PC wrap from RESET_PC=FFFF_FFF8.
        chk("G_rst_addr", addr1, 32'hFFFF_FFF8);
        chk("G_rst_req", {31'h0, req1}, 32'h0);
        @(posedge clk);
        #2;
        rst1_n = 1'b1;
        push1(32'hFFFF_FFF8, 32'hFFFF_FFFC);
        push1(32'hFFFF_FFFC, 32'h0);
        push1(32'h0, 32'h4);
        cyc();
        chk("G_addr_fff8", addr1, 32'hFFFF_FFF8);
        cyc();
        chk("G_addr_fffc", addr1, 32'hFFFF_FFFC);
        cyc();
        chk("G_addr_0", addr1, 32'h0);
        cyc();
        chk("G_addr_4", addr1, 32'h4);
        @(negedge clk);
        #1;
        rst1_n = 1'b0;
        chk("sb1_drained", 32'(q1.size()), 32'd0);
        chk("sb0_final", 32'(q0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core: owns the PC, talks to instruction memory with a req/ready handshake, and holds the IF/ID pipeline register.
- Directly upstream of the main decoder: op_d (instr_d[31:26]) drives the decoder's op input.
- Absorbs memory wait states, hazard-unit stalls, and branch/jump redirects from the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch byte address; bits [1:0] always 0.
- imem_ready  in  1  response valid this cycle; may rise in the same cycle as imem_req.
- imem_rdata  in  32  instruction word; valid only when imem_ready=1.
- stall_i  in  1  hazard unit: hold IF/ID contents.
- flush_i  in  1  squash IF/ID contents.
- redirect_valid  in  1  take branch/jump target.
- redirect_pc  in  32  target address; bits [1:0] are ignored and forced to 0.
- instr_d  out  32  IF/ID instruction.
- pcplus4_d  out  32  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.
- op_d  out  6  instr_d[31:26], combinational, to the main decoder.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - pc_f=RESET_PC, state=IDLE.
  - imem_req=0, valid_d=0, instr_d=32'h0, pcplus4_d=0, skid=0, redir_pc=0.
  - Reset mid-handshake abandons the outstanding request; memory must tolerate this.
- States: IDLE, FETCH, DRAIN, HOLD.
- Handshake: while imem_req=1, imem_addr stays stable until a cycle with imem_ready=1. One request is outstanding at most.
- IDLE: imem_req=0; moves to FETCH unconditionally on the next cycle.
- FETCH: imem_req=1, imem_addr=pc_f.
  - imem_ready & redirect_valid: discard rdata; pc_f<=redirect_pc; stay in FETCH.
  - imem_ready & !stall_i: IF/ID<={rdata, pc_f+4}, valid_d<=1; pc_f<=pc_f+4.
  - imem_ready & stall_i: skid<=rdata; pc_f<=pc_f+4; go to HOLD.
  - !imem_ready & redirect_valid: redir_pc<=redirect_pc; go to DRAIN.
  - !imem_ready & !stall_i: insert a bubble (valid_d<=0, instr_d<=0).
- DRAIN: imem_req=1 with the old pc_f, which must be held per the handshake rule.
  - A new redirect_valid overwrites redir_pc.
  - On imem_ready: discard rdata; pc_f<=redir_pc; go to FETCH.
  - IF/ID receives bubbles unless stalled.
- HOLD: imem_req=0.
  - redirect_valid: drop skid; pc_f<=redirect_pc; go to FETCH.
  - else !stall_i: IF/ID<={skid, pc_f}; valid_d<=1; go to FETCH. pc_f is already the successor address, so pcplus4_d=pc_f.
- IF/ID update priority: flush_i > stall_i > load/bubble.
  - flush_i: next cycle valid_d=0 and instr_d=32'h0 (sll $0 nop, decodes harmlessly), regardless of stall_i.
  - stall_i (without flush_i): instr_d, pcplus4_d and valid_d all hold.
- redirect_valid does not by itself clear IF/ID; the hazard unit asserts flush_i alongside it.
- Arithmetic: pc_f+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- Latency: with zero-wait memory and no stalls, one instruction enters IF/ID per cycle. The first valid_d=1 appears on the 2nd rising edge after reset deasserts (IDLE, then FETCH).

Decomposition:
- Shared package mips_pkg holds:
  - fetch_state_t enum {IDLE, FETCH, DRAIN, HOLD}
  - NOP_INSTR = 32'h0
  - default RESET_PC constant
- Sub-module if_id_reg: flush/stall/load register for {instr, pcplus4, valid}. The fetch FSM and PC logic stay in fetch_stage.

Test Plan:
- Reset then zero-wait memory (ready=req), stream of words at 0,4,8: instr_d follows with valid_d=1 every cycle; pcplus4_d=4,8,12; op_d=instr_d[31:26].
- Memory inserts 2 wait states at addr 8: imem_addr holds 8 for 3 cycles; valid_d=0 for 2 cycles, then the word for addr 8 appears with pcplus4_d=12.
- stall_i held 3 cycles while ready returns addr 4: IF/ID holds the old instruction; state HOLD with imem_req=0; after release, the word for addr 4 appears with pcplus4_d=8 and fetch resumes at 8.
- redirect_valid to 32'h40 while a request for addr 12 is waiting: DRAIN keeps imem_addr=12 until ready; that data never reaches IF/ID; next imem_addr=32'h40.
- flush_i together with stall_i: next cycle valid_d=0, instr_d=0; redirect in HOLD drops the skid word.
- RESET_PC=32'hFFFF_FFF8: fetches FFF8, FFFC, then 0; pcplus4_d=FFFC, 0, 4. Async reset_n pulse mid-DRAIN: outputs return to reset values immediately.
